// File: rtl/cmp_result_filter.sv
// Hysteresis filter for the ADC comparison bit: samples on each cs_n rise,
// produces a debounced alarm, a one-cycle rise pulse and a saturating trip count.
module cmp_result_filter #(
  parameter int unsigned CONFIRM_COUNT = 3,
  parameter int unsigned RELEASE_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n_i,
  input  logic       comparison_result_i,
  input  logic       clear_count_i,
  output logic       alarm_o,
  output logic       alarm_edge_o,
  output logic [3:0] trip_count_o
);

  typedef enum logic [1:0] {
    CLEAR    = 2'd0,
    PEND_SET = 2'd1,
    ALARM    = 2'd2,
    PEND_CLR = 2'd3
  } state_e;

  localparam logic [3:0] CONFIRM_L = 4'(CONFIRM_COUNT);
  localparam logic [3:0] RELEASE_L = 4'(RELEASE_COUNT);

  state_e     state_q, state_d;
  logic [3:0] run_q, run_d;
  logic [3:0] trip_q, trip_d;
  logic       cs_q, rise_q, alarm_q, edge_q;
  logic       rise, fire, sample;
  logic [3:0] run_inc;

  assign rise    = cs_n_i & ~cs_q;
  assign sample  = comparison_result_i;
  assign run_inc = run_q + 4'd1;

  // The data bit is consumed only in the cycle after the cs_n rise was seen.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    fire    = 1'b0;
    if (rise_q) begin
      case (state_q)
        CLEAR: begin
          if (sample) begin
            if (CONFIRM_L == 4'd1) begin
              state_d = ALARM;
              run_d   = 4'd0;
              fire    = 1'b1;
            end else begin
              state_d = PEND_SET;
              run_d   = 4'd1;
            end
          end
        end
        PEND_SET: begin
          if (sample) begin
            if (run_inc == CONFIRM_L) begin
              state_d = ALARM;
              run_d   = 4'd0;
              fire    = 1'b1;
            end else begin
              run_d = run_inc;
            end
          end else begin
            state_d = CLEAR;
            run_d   = 4'd0;
          end
        end
        ALARM: begin
          if (!sample) begin
            if (RELEASE_L == 4'd1) begin
              state_d = CLEAR;
              run_d   = 4'd0;
            end else begin
              state_d = PEND_CLR;
              run_d   = 4'd1;
            end
          end
        end
        PEND_CLR: begin
          if (!sample) begin
            if (run_inc == RELEASE_L) begin
              state_d = CLEAR;
              run_d   = 4'd0;
            end else begin
              run_d = run_inc;
            end
          end else begin
            state_d = ALARM;
            run_d   = 4'd0;
          end
        end
        default: begin
          state_d = CLEAR;
          run_d   = 4'd0;
        end
      endcase
    end
  end

  // A clear coinciding with a new trip leaves the count at 1 so that trip is kept.
  always_comb begin
    trip_d = trip_q;
    if (clear_count_i) begin
      trip_d = fire ? 4'd1 : 4'd0;
    end else if (fire && (trip_q != 4'hF)) begin
      trip_d = trip_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q    <= 1'b1;
      rise_q  <= 1'b0;
      state_q <= CLEAR;
      run_q   <= 4'd0;
      alarm_q <= 1'b0;
      edge_q  <= 1'b0;
      trip_q  <= 4'd0;
    end else begin
      cs_q    <= cs_n_i;
      rise_q  <= rise;
      state_q <= state_d;
      run_q   <= run_d;
      alarm_q <= (state_d == ALARM) || (state_d == PEND_CLR);
      edge_q  <= fire;
      trip_q  <= trip_d;
    end
  end

  assign alarm_o      = alarm_q;
  assign alarm_edge_o = edge_q;
  assign trip_count_o = trip_q;

endmodule

// File: tb/tb_cmp_result_filter.sv
// Bench for cmp_result_filter: one instance with 3/3 hysteresis, one with 1/1,
// both fed the same stimulus and checked every cycle against a streak model.
module tb_cmp_result_filter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       csN = 1'b1;
  logic       compResult = 1'b0;
  logic       clearCount = 1'b0;
  logic       alarm3, edge3, alarm1, edge1;
  logic [3:0] trip3, trip1;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  cmp_result_filter #(.CONFIRM_COUNT(3), .RELEASE_COUNT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cs_n_i(csN), .comparison_result_i(compResult),
    .clear_count_i(clearCount), .alarm_o(alarm3), .alarm_edge_o(edge3),
    .trip_count_o(trip3)
  );

  cmp_result_filter #(.CONFIRM_COUNT(1), .RELEASE_COUNT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cs_n_i(csN), .comparison_result_i(compResult),
    .clear_count_i(clearCount), .alarm_o(alarm1), .alarm_edge_o(edge1),
    .trip_count_o(trip1)
  );

  // Reference: an alarm flips once THR consecutive samples disagree with it.
  int thr[2] = '{3, 1};
  bit mPrevCs[2];
  bit mPend[2];
  bit mAlarm[2];
  bit mEdge[2];
  int mStreak[2];
  int mTrip[2];

  function automatic void modelReset();
    for (int m = 0; m < 2; m++) begin
      mPrevCs[m] = 1'b1;
      mPend[m]   = 1'b0;
      mAlarm[m]  = 1'b0;
      mEdge[m]   = 1'b0;
      mStreak[m] = 0;
      mTrip[m]   = 0;
    end
  endfunction

  function automatic void modelStep(bit cs, bit res, bit clr);
    for (int m = 0; m < 2; m++) begin
      bit fire = 1'b0;
      if (mPend[m]) begin
        if (res != mAlarm[m]) mStreak[m]++;
        else mStreak[m] = 0;
        if (mStreak[m] == thr[m]) begin
          mAlarm[m]  = !mAlarm[m];
          mStreak[m] = 0;
          fire       = mAlarm[m];
        end
      end
      mEdge[m] = fire;
      if (clr) mTrip[m] = fire ? 1 : 0;
      else if (fire && mTrip[m] < 15) mTrip[m]++;
      mPend[m]   = cs && !mPrevCs[m];
      mPrevCs[m] = cs;
    end
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("alarm3", int'(alarm3), int'(mAlarm[0]));
    checkOutput("edge3", int'(edge3), int'(mEdge[0]));
    checkOutput("trip3", int'(trip3), mTrip[0]);
    checkOutput("alarm1", int'(alarm1), int'(mAlarm[1]));
    checkOutput("edge1", int'(edge1), int'(mEdge[1]));
    checkOutput("trip1", int'(trip1), mTrip[1]);
  endtask

  // Drive at the falling edge, advance the model at the rising edge, compare at the next falling edge.
  task automatic applyStimulus(bit cs, bit res, bit clr);
    csN        = cs;
    compResult = res;
    clearCount = clr;
    @(posedge clk);
    if (!rst_n) modelReset();
    else modelStep(cs, res, clr);
    @(negedge clk);
    checkAll();
  endtask

  task automatic conversion(bit res, bit clr);
    applyStimulus(1'b0, res, 1'b0);
    applyStimulus(1'b1, res, 1'b0);
    applyStimulus(1'b1, res, clr);
  endtask

  typedef struct {
    bit res;
    bit clr;
    bit expAlarm;
    int expTrip;
    bit expEdge;
  } vecT;

  vecT vecs[18];

  initial begin
    vecs[0]  = '{1, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 1, 1, 1};
    vecs[3]  = '{0, 0, 1, 1, 0};
    vecs[4]  = '{0, 0, 1, 1, 0};
    vecs[5]  = '{1, 0, 1, 1, 0};
    vecs[6]  = '{0, 0, 1, 1, 0};
    vecs[7]  = '{0, 0, 1, 1, 0};
    vecs[8]  = '{0, 0, 0, 1, 0};
    vecs[9]  = '{1, 0, 0, 1, 0};
    vecs[10] = '{1, 0, 0, 1, 0};
    vecs[11] = '{0, 0, 0, 1, 0};
    vecs[12] = '{1, 0, 0, 1, 0};
    vecs[13] = '{1, 0, 0, 1, 0};
    vecs[14] = '{0, 1, 0, 0, 0};
    vecs[15] = '{1, 0, 0, 0, 0};
    vecs[16] = '{1, 0, 0, 0, 0};
    vecs[17] = '{1, 0, 1, 1, 1};

    modelReset();
    @(negedge clk);
    checkOutput("reset_alarm3", int'(alarm3), 0);
    checkOutput("reset_trip3", int'(trip3), 0);
    checkOutput("reset_edge3", int'(edge3), 0);

    // cs_n held high through release must not produce a strobe.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("no_strobe_alarm3", int'(alarm3), 0);

    for (int i = 0; i < 18; i++) begin
      conversion(vecs[i].res, vecs[i].clr);
      checkOutput($sformatf("vec%0d_alarm", i), int'(alarm3), int'(vecs[i].expAlarm));
      checkOutput($sformatf("vec%0d_trip", i), int'(trip3), vecs[i].expTrip);
      checkOutput($sformatf("vec%0d_edge", i), int'(edge3), int'(vecs[i].expEdge));
    end

    // Result toggling with no cs_n rise is ignored.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'($urandom), 1'b0);
    checkOutput("toggle_alarm3", int'(alarm3), 1);

    // Reset while two confirming samples are pending.
    for (int i = 0; i < 3; i++) conversion(1'b0, 1'b0);
    conversion(1'b1, 1'b0);
    conversion(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_trip3", int'(trip3), 0);
    checkOutput("midreset_alarm3", int'(alarm3), 0);
    modelReset();
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    conversion(1'b1, 1'b0);
    conversion(1'b1, 1'b0);
    checkOutput("fresh_two_alarm3", int'(alarm3), 0);
    conversion(1'b1, 1'b0);
    checkOutput("fresh_three_alarm3", int'(alarm3), 1);
    checkOutput("fresh_three_trip3", int'(trip3), 1);

    for (int i = 0; i < 3; i++) conversion(1'b0, 1'b0);
    for (int b = 0; b < 18; b++) begin
      for (int i = 0; i < 3; i++) conversion(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) conversion(1'b0, 1'b0);
    end
    checkOutput("saturate_trip3", int'(trip3), 15);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("clear_trip3", int'(trip3), 0);
    conversion(1'b1, 1'b0);
    conversion(1'b1, 1'b0);
    conversion(1'b1, 1'b1);
    checkOutput("clear_with_trip_trip3", int'(trip3), 1);
    checkOutput("clear_with_trip_alarm3", int'(alarm3), 1);

    // Fastest possible cs_n rises on the 1/1 instance; every one is sampled.
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("fast_low_alarm1", int'(alarm1), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("fast_high_alarm1", int'(alarm1), 1);
    checkOutput("fast_high_edge1", int'(edge1), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("fast_low2_alarm1", int'(alarm1), 0);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 40) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
